// File: rtl/jtag_idcode_reader.sv
// JTAG IDCODE reader: walks a target TAP through reset, IR load and DR shift
// and returns the captured data register contents.
module jtag_idcode_reader #(
    parameter int IR_WIDTH     = 4,
    parameter int DR_WIDTH     = 32,
    parameter int RESET_CYCLES = 5
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                start,
    input  logic [IR_WIDTH-1:0] ir_in,
    output logic                tms_out,
    output logic                tdi_out,
    input  logic                tdo_in,
    output logic                busy,
    output logic                done,
    output logic [DR_WIDTH-1:0] result,
    output logic                id_ok
);

    localparam int MAX_A = (RESET_CYCLES > IR_WIDTH) ? RESET_CYCLES : IR_WIDTH;
    localparam int MAX_B = (MAX_A > DR_WIDTH) ? MAX_A : DR_WIDTH;
    localparam int MAX_C = (MAX_B > 4) ? MAX_B : 4;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] RC_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] IR_LAST   = CNT_W'(IR_WIDTH - 1);
    localparam logic [CNT_W-1:0] IR_PEN    = CNT_W'(IR_WIDTH - 2);
    localparam logic [CNT_W-1:0] DR_LAST   = CNT_W'(DR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DR_PEN    = CNT_W'(DR_WIDTH - 2);
    localparam logic [CNT_W-1:0] PATH_LAST = CNT_W'(3);

    typedef enum logic [3:0] {
        IDLE,
        TLR,
        RTI,
        SEL_IR_PATH,
        SHIFT_IR,
        UPD_IR_PATH,
        SHIFT_DR,
        UPD_DR_PATH,
        DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IR_WIDTH-1:0] r_ir;
    logic [DR_WIDTH-1:0] r_shift;
    logic                r_tms;
    logic                r_tdi;
    logic                r_busy;
    logic                r_done;
    logic [DR_WIDTH-1:0] r_result;
    logic                r_id_ok;

    assign tms_out = r_tms;
    assign tdi_out = r_tdi;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign id_ok   = r_id_ok;

    // Sequencer: each transition loads the TMS/TDI bit for the following cycle.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ir     <= '0;
            r_shift  <= '0;
            r_tms    <= 1'b1;
            r_tdi    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_id_ok  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= TLR;
                        r_cnt   <= '0;
                        r_ir    <= ir_in;
                        r_tms   <= 1'b1;
                        r_tdi   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                TLR: begin
                    if (r_cnt == RC_LAST) begin
                        r_state <= RTI;
                        r_cnt   <= '0;
                        r_tms   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_tms <= 1'b1;
                    end
                end
                RTI: begin
                    r_state <= SEL_IR_PATH;
                    r_cnt   <= '0;
                    r_tms   <= 1'b1;
                end
                SEL_IR_PATH: begin
                    if (r_cnt == PATH_LAST) begin
                        r_state <= SHIFT_IR;
                        r_cnt   <= '0;
                        r_tms   <= (IR_WIDTH == 1);
                        r_tdi   <= r_ir[0];
                        r_ir    <= r_ir >> 1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_tms <= (r_cnt == '0);
                    end
                end
                SHIFT_IR: begin
                    if (r_cnt == IR_LAST) begin
                        r_state <= UPD_IR_PATH;
                        r_cnt   <= '0;
                        r_tms   <= 1'b1;
                        r_tdi   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_tms <= (r_cnt == IR_PEN);
                        r_tdi <= r_ir[0];
                        r_ir  <= r_ir >> 1;
                    end
                end
                UPD_IR_PATH: begin
                    if (r_cnt == PATH_LAST) begin
                        r_state <= SHIFT_DR;
                        r_cnt   <= '0;
                        r_tms   <= (DR_WIDTH == 1);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_tms <= (r_cnt == '0);
                    end
                end
                SHIFT_DR: begin
                    r_shift <= {tdo_in, r_shift[DR_WIDTH-1:1]};
                    if (r_cnt == DR_LAST) begin
                        r_state <= UPD_DR_PATH;
                        r_cnt   <= '0;
                        r_tms   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_tms <= (r_cnt == DR_PEN);
                    end
                end
                UPD_DR_PATH: begin
                    r_tms <= 1'b0;
                    if (r_cnt == '0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_state  <= DONE;
                        r_cnt    <= '0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= r_shift;
                        r_id_ok  <= r_shift[0] && !(&r_shift);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_tms   <= 1'b1;
                    r_tdi   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Testbench for jtag_idcode_reader: behavioural TAP target plus a
// scoreboard of expected results per accepted start.
module tb_jtag_idcode_reader;

    localparam int IRW = 4;
    localparam int DRW = 32;
    localparam int RC  = 5;
    localparam int SEQ = RC + 11 + IRW + DRW;

    localparam logic [SEQ-1:0] TMS_REF =
        {5'b11111, 1'b0, 4'b1100, 4'b0001, 4'b1100, 31'd0, 1'b1, 2'b10};

    logic           tck = 1'b0;
    logic           trst_n = 1'b1;
    logic           start = 1'b0;
    logic [IRW-1:0] ir_in = '0;
    logic           tms_out;
    logic           tdi_out;
    logic           tdo_in;
    logic           busy;
    logic           done;
    logic [DRW-1:0] result;
    logic           id_ok;

    jtag_idcode_reader #(
        .IR_WIDTH(IRW),
        .DR_WIDTH(DRW),
        .RESET_CYCLES(RC)
    ) dut (
        .tck(tck),
        .trst_n(trst_n),
        .start(start),
        .ir_in(ir_in),
        .tms_out(tms_out),
        .tdi_out(tdi_out),
        .tdo_in(tdo_in),
        .busy(busy),
        .done(done),
        .result(result),
        .id_ok(id_ok)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Target TAP controller model
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR,
        T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
    } tap_t;

    tap_t           tap_st = T_TLR;
    logic [DRW-1:0] tap_id = '0;
    logic [DRW-1:0] tap_dr = '0;
    logic [IRW-1:0] tap_irsh = '0;
    logic [IRW-1:0] tap_ir = '0;

    always @(posedge tck) begin
        case (tap_st)
            T_TLR:   tap_st <= tms_out ? T_TLR   : T_RTI;
            T_RTI:   tap_st <= tms_out ? T_SELDR : T_RTI;
            T_SELDR: tap_st <= tms_out ? T_SELIR : T_CAPDR;
            T_CAPDR: tap_st <= tms_out ? T_EX1DR : T_SHDR;
            T_SHDR:  tap_st <= tms_out ? T_EX1DR : T_SHDR;
            T_EX1DR: tap_st <= tms_out ? T_UPDR  : T_PADR;
            T_PADR:  tap_st <= tms_out ? T_EX2DR : T_PADR;
            T_EX2DR: tap_st <= tms_out ? T_UPDR  : T_SHDR;
            T_UPDR:  tap_st <= tms_out ? T_SELDR : T_RTI;
            T_SELIR: tap_st <= tms_out ? T_TLR   : T_CAPIR;
            T_CAPIR: tap_st <= tms_out ? T_EX1IR : T_SHIR;
            T_SHIR:  tap_st <= tms_out ? T_EX1IR : T_SHIR;
            T_EX1IR: tap_st <= tms_out ? T_UPIR  : T_PAIR;
            T_PAIR:  tap_st <= tms_out ? T_EX2IR : T_PAIR;
            T_EX2IR: tap_st <= tms_out ? T_UPIR  : T_SHIR;
            T_UPIR:  tap_st <= tms_out ? T_SELDR : T_RTI;
            default: tap_st <= T_TLR;
        endcase
        if (tap_st == T_CAPDR) tap_dr <= tap_id;
        if (tap_st == T_SHDR) tap_dr <= {tdi_out, tap_dr[DRW-1:1]};
        if (tap_st == T_CAPIR) tap_irsh <= 4'b0001;
        if (tap_st == T_SHIR) tap_irsh <= {tdi_out, tap_irsh[IRW-1:1]};
        if (tap_st == T_UPIR) tap_ir <= tap_irsh;
    end

    assign tdo_in = tap_dr[0];

    // Scoreboard
    typedef struct {
        logic [DRW-1:0] res;
        logic           ok;
        logic [IRW-1:0] ir;
        logic [SEQ-1:0] tdi;
    } exp_t;

    exp_t sb[$];

    logic [SEQ-1:0] rec_tms = '0;
    logic [SEQ-1:0] rec_tdi = '0;
    int             n = 0;
    int             done_cnt = 0;

    always @(negedge tck) begin
        if (!trst_n) begin
            n <= 0;
        end else begin
            if (busy && n < SEQ) begin
                rec_tms[SEQ-1-n] <= tms_out;
                rec_tdi[SEQ-1-n] <= tdi_out;
            end
            if (busy) n <= n + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    chk("result", result, sb[0].res);
                    chk("id_ok", id_ok, sb[0].ok);
                    chk("tms_seq", rec_tms, TMS_REF);
                    chk("tdi_seq", rec_tdi, sb[0].tdi);
                    chk("seq_len", n, SEQ);
                    chk("tap_ir", tap_ir, sb[0].ir);
                    sb.delete(0);
                end
                n <= 0;
            end
        end
    end

    task automatic run_start(input logic [IRW-1:0] ir,
                             input logic [DRW-1:0] id);
        exp_t e;
        e.res = id;
        e.ok  = id[0] && (id != {DRW{1'b1}});
        e.ir  = ir;
        e.tdi = '0;
        for (int k = 0; k < IRW; k++) e.tdi[SEQ-1-(RC+5+k)] = ir[k];
        tap_id = id;
        sb.push_back(e);
        @(posedge tck);
        #1;
        start = 1'b1;
        ir_in = ir;
        @(posedge tck);
        #1;
        start = 1'b0;
        ir_in = ~ir;
        @(negedge tck);
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge tck);
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic idle_checks(input logic [DRW-1:0] res);
        repeat (3) @(negedge tck);
        chk("idle_tms", tms_out, 0);
        chk("idle_tdi", tdi_out, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("result_hold", result, res);
    endtask

    int dc0;

    initial begin
        #2;
        trst_n = 1'b0;
        @(negedge tck);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_id_ok", id_ok, 0);
        chk("rst_tms", tms_out, 1);
        chk("rst_tdi", tdi_out, 0);
        repeat (2) @(negedge tck);
        @(posedge tck);
        #1;
        trst_n = 1'b1;
        repeat (3) @(negedge tck);
        chk("tms_after_release", tms_out, 1);

        run_start(4'b1110, 32'h000FAF01);
        wait_done(SEQ + 10);
        idle_checks(32'h000FAF01);

        run_start(4'b1111, 32'h80000002);
        wait_done(SEQ + 10);
        idle_checks(32'h80000002);

        run_start(4'b1110, 32'hFFFFFFFF);
        wait_done(SEQ + 10);
        idle_checks(32'hFFFFFFFF);

        run_start(4'b1110, 32'h00000000);
        wait_done(SEQ + 10);
        idle_checks(32'h00000000);

        dc0 = done_cnt;
        run_start(4'b1110, 32'hDEADBEEF);
        repeat (9) @(negedge tck);
        start = 1'b1;
        ir_in = 4'b0000;
        @(posedge tck);
        #1;
        start = 1'b0;
        wait_done(SEQ + 10);
        start = 1'b1;
        ir_in = 4'b1110;
        @(posedge tck);
        #1;
        start = 1'b0;
        @(negedge tck);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        repeat (5) @(negedge tck);
        chk("single_done", done_cnt - dc0, 1);

        dc0 = done_cnt;
        run_start(4'b1110, 32'h12345671);
        repeat (19) @(negedge tck);
        trst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_tms", tms_out, 1);
        chk("abort_done", done, 0);
        chk("abort_id_ok", id_ok, 0);
        sb.delete();
        @(posedge tck);
        #1;
        trst_n = 1'b1;
        repeat (SEQ + 5) @(negedge tck);
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_tms_hold", tms_out, 1);
        chk("abort_result_hold", result, 0);

        run_start(4'b1110, 32'h0BADF00D);
        wait_done(SEQ + 10);
        idle_checks(32'h0BADF00D);

        repeat (3) @(negedge tck);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_idcode_reader.md
JTAG_IDCODE_READER -- requirements
Module: jtag_idcode_reader

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register length of the target TAP.
REQ-002 Parameter DR_WIDTH, default 32: data register length to be shifted out.
REQ-003 Parameter RESET_CYCLES, default 5: number of TMS=1 cycles used to force the target into Test-Logic-Reset.
REQ-004 Port: tck, input, 1, the only clock; all state updates on its rising edge.
REQ-005 Port: trst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: start, input, 1, one-cycle request to begin a read sequence.
REQ-007 Port: ir_in, input, IR_WIDTH, instruction to load (IDCODE = 4'b1110); latched on an accepted start.
REQ-008 Port: tms_out, output, 1, registered TMS driven to the target TAP.
REQ-009 Port: tdi_out, output, 1, registered TDI driven to the target TAP.
REQ-010 Port: tdo_in, input, 1, TDO returned from the target TAP.
REQ-011 Port: busy, output, 1, high while a sequence is in progress.
REQ-012 Port: done, output, 1, one-cycle pulse when the sequence completes.
REQ-013 Port: result, output, DR_WIDTH, captured DR contents; held stable until the next accepted start.
REQ-014 Port: id_ok, output, 1, valid with done and then held: result[0]==1 and result is not all-ones.

Function
REQ-015 The block SHALL accept start only when busy==0; start while busy SHALL be ignored.
REQ-016 On the cycle after an accepted start, busy SHALL rise, and ir_in SHALL be latched.
REQ-017 The sequence SHALL be driven as one TMS bit per tck cycle, in this order, on tms_out:
- RESET_CYCLES × 1 (Test-Logic-Reset)
- 0 (to Run-Test/Idle)
- 1, 1, 0, 0 (Select-DR, Select-IR, Capture-IR, Shift-IR)
- IR_WIDTH bits: 0 on every bit except 1 on the last (to Exit1-IR)
- 1, 1, 0, 0 (Update-IR, Select-DR, Capture-DR, Shift-DR)
- DR_WIDTH bits: 0 on every bit except 1 on the last (to Exit1-DR)
- 1, 0 (Update-DR, Run-Test/Idle)
REQ-018 The total sequence length SHALL be RESET_CYCLES+11+IR_WIDTH+DR_WIDTH cycles; this is 52 at the defaults.
REQ-019 During the IR segment, tdi_out SHALL present the latched instruction LSB first, bit k on IR cycle k; outside the IR segment tdi_out SHALL be 0.
REQ-020 During the DR segment, tdo_in SHALL be sampled at the rising edge ending each DR cycle.
- The first sample goes to result[0], the last to result[DR_WIDTH-1].
- result is built in an internal shift register; the visible result updates only at done.
REQ-021 Internal FSM states SHALL be IDLE, TLR, RTI, SEL_IR_PATH, SHIFT_IR, UPD_IR_PATH, SHIFT_DR, UPD_DR_PATH and DONE.
- A single bit counter, width clog2(max(RESET_CYCLES, IR_WIDTH, DR_WIDTH)+1), sequences the multi-cycle states.
- The counter SHALL clear on every state entry.
REQ-022 done SHALL pulse for exactly one cycle, the cycle after the final TMS=0 bit has been driven. busy SHALL fall in the same cycle, and result and id_ok SHALL update in the same cycle.
REQ-023 A start asserted in the same cycle as done SHALL be ignored; the earliest accepted start is the cycle after done.
REQ-024 In IDLE after any completed sequence, tms_out SHALL be 0 and tdi_out SHALL be 0, holding the target in Run-Test/Idle.
REQ-025 Undefined or unreachable FSM encodings SHALL return to IDLE with tms_out=1.

Reset
REQ-026 While trst_n==0, the following SHALL hold:
- busy=0, done=0, result=0, id_ok=0
- tms_out=1, tdi_out=0
- FSM in IDLE with counter cleared
REQ-027 Reset asserted mid-sequence SHALL abort immediately without a done pulse. result SHALL be cleared, and tms_out=1 SHALL be held so the target drifts to Test-Logic-Reset.
REQ-028 After reset release, tms_out SHALL remain 1 until the first accepted start.

Verification
REQ-029 Default parameters, start with ir_in=4'b1110 and a TAP model returning IDCODE 32'h000FAF01 -> done 52 cycles after busy rises, result=32'h000FAF01, id_ok=1.
REQ-030 Record tms_out across one sequence -> bit-exact match with 11111 0 1100 0001 1100 (31×0)1 10.
REQ-031 Record tdi_out with ir_in=4'b1111 -> 1 on exactly the 4 IR cycles, 0 on all other cycles.
REQ-032 TAP model returning all ones -> result=32'hFFFFFFFF, id_ok=0; all zeros -> result=0, id_ok=0.
REQ-033 Start pulses at cycle 10 of a sequence and in the done cycle -> both ignored; exactly one done pulse; busy low for at least one cycle.
REQ-034 trst_n pulsed low at cycle 20 of a sequence -> no done pulse, result=0, tms_out=1; a new start after release completes normally.
